// File: rtl/cfe_trigger_scheduler.sv
// -----------------------------------------------------------------------------
// cfe_trigger_scheduler
//
// Turns the feedback wait value into carrier-frequency-estimator start
// requests. One request is issued, the estimate (or a timeout) is awaited,
// then i_wait cycles are counted down before the next request, so the
// estimate rate follows the feedback loop.
//
// Ports
//   clk          rising-edge clock
//   rst_async_n  asynchronous active-low reset
//   i_enable     scheduler enable
//   i_wait       inter-estimate wait in cycles (sampled once, in LOAD)
//   i_cfe_ready  CFE can accept a start (only looked at in REQ)
//   i_cfe_valid  CFE estimate valid (only looked at in RUN)
//   o_cfe_start  start request, held until accepted
//   o_busy       high in REQ or RUN
//   o_timeout    one-cycle pulse in the cycle after an estimate timed out
//   o_wait_cnt   remaining wait cycles, 0 outside WAIT
//   o_est_cnt    completed estimates, saturating
//   o_state      debug state: IDLE=0 REQ=1 RUN=2 LOAD=3 WAIT=4
// -----------------------------------------------------------------------------
module cfe_trigger_scheduler #(
    parameter int CFE_NBW_LAT = 32,
    parameter int CFE_NBW_TO  = 16,
    parameter int CFE_TIMEOUT = 16'h4000,
    parameter int CFE_NBW_CNT = 16
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   i_enable,
    input  logic [CFE_NBW_LAT-1:0] i_wait,
    input  logic                   i_cfe_ready,
    input  logic                   i_cfe_valid,
    output logic                   o_cfe_start,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic [CFE_NBW_LAT-1:0] o_wait_cnt,
    output logic [CFE_NBW_CNT-1:0] o_est_cnt,
    output logic [2:0]             o_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RUN  = 3'd2,
        ST_LOAD = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    // Timeout counter value seen in the last permitted RUN cycle.
    localparam logic [CFE_NBW_TO-1:0]  TO_LAST = CFE_NBW_TO'(CFE_TIMEOUT - 1);
    localparam logic [CFE_NBW_CNT-1:0] EST_MAX = '1;
    localparam logic [CFE_NBW_LAT-1:0] LAT_ONE = CFE_NBW_LAT'(1);

    state_t                 state_reg,    state_next;
    logic [CFE_NBW_TO-1:0]  to_cnt_reg,   to_cnt_next;
    logic [CFE_NBW_LAT-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CFE_NBW_CNT-1:0] est_cnt_reg,  est_cnt_next;
    logic                   timeout_reg,  timeout_next;
    logic                   start_reg;
    logic                   busy_reg;
    logic                   run_done;

    always_comb begin
        state_next    = state_reg;
        to_cnt_next   = to_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        est_cnt_next  = est_cnt_reg;
        timeout_next  = 1'b0;
        run_done      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_enable) begin
                    state_next = ST_REQ;
                end
            end

            ST_REQ: begin
                // A completed handshake is honoured even if enable drops in
                // the same cycle: the CFE has already accepted the start.
                if (i_cfe_ready) begin
                    state_next  = ST_RUN;
                    to_cnt_next = '0;
                end else if (!i_enable) begin
                    state_next = ST_IDLE;
                end
            end

            ST_RUN: begin
                to_cnt_next = to_cnt_reg + 1'b1;
                // Valid takes priority over a coincident timeout.
                if (i_cfe_valid) begin
                    run_done = 1'b1;
                    if (est_cnt_reg != EST_MAX) begin
                        est_cnt_next = est_cnt_reg + 1'b1;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    run_done     = 1'b1;
                    timeout_next = 1'b1;
                end
                // RUN is only left on valid or timeout, never on disable.
                if (run_done) begin
                    state_next = i_enable ? ST_LOAD : ST_IDLE;
                end
            end

            ST_LOAD: begin
                // The extra cycle lets the feedback stage settle its wait.
                if (i_enable) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = (i_wait == '0) ? LAT_ONE : i_wait;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (!i_enable) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg <= LAT_ONE) begin
                    // The count shown as 1 is the last WAIT cycle.
                    state_next    = ST_REQ;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_reg    <= ST_IDLE;
            to_cnt_reg   <= '0;
            wait_cnt_reg <= '0;
            est_cnt_reg  <= '0;
            timeout_reg  <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            to_cnt_reg   <= to_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            est_cnt_reg  <= est_cnt_next;
            timeout_reg  <= timeout_next;
            // Decodes are registered from the next state so the outputs come
            // straight off flops and cannot glitch on state bit changes.
            start_reg    <= (state_next == ST_REQ);
            busy_reg     <= (state_next == ST_REQ) || (state_next == ST_RUN);
        end
    end

    assign o_cfe_start = start_reg;
    assign o_busy      = busy_reg;
    assign o_timeout   = timeout_reg;
    assign o_wait_cnt  = wait_cnt_reg;
    assign o_est_cnt   = est_cnt_reg;
    assign o_state     = state_reg;

endmodule

// File: doc/cfe_trigger_scheduler.md
# cfe_trigger_scheduler

Downstream consumer of the CFE wait-feedback stage. It turns the feedback wait value `i_wait` into CFE start requests. It issues a start to the carrier-frequency estimator, waits for the estimate (or a timeout), then counts down `i_wait` cycles before the next request. Estimates are therefore spaced adaptively by the feedback loop.

## Interface
- CFE_NBW_LAT, 32: width of `i_wait` and of the countdown counter.
- CFE_NBW_TO, 16: width of the timeout counter.
- CFE_TIMEOUT, 16'h4000: number of cycles spent in RUN without `i_cfe_valid` before a timeout is declared; legal range ≥1.
- CFE_NBW_CNT, 16: width of the estimate counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_async_n  in  1  reset, asynchronous assert, active-low.
- i_enable  in  1  scheduler enable.
- i_wait  in  CFE_NBW_LAT  inter-estimate wait in cycles, driven by the feedback stage.
- i_cfe_ready  in  1  CFE can accept a start.
- i_cfe_valid  in  1  CFE estimate valid; the same strobe also feeds the feedback stage.
- o_cfe_start  out  1  start request; held until accepted.
- o_busy  out  1  high in REQ or RUN.
- o_timeout  out  1  one-cycle pulse when an estimate times out.
- o_wait_cnt  out  CFE_NBW_LAT  remaining wait cycles; 0 outside WAIT.
- o_est_cnt  out  CFE_NBW_CNT  completed estimates; saturating.
- o_state  out  3  FSM state for debug: IDLE=0, REQ=1, RUN=2, LOAD=3, WAIT=4.

## Operation
- States: IDLE, REQ, RUN, LOAD, WAIT. All outputs are registered.
- IDLE: if `i_enable`=1, go to REQ. The first estimate after enable is immediate.
- REQ: `o_cfe_start`=1.
  - `i_cfe_ready`=1 completes the handshake; go to RUN and clear the timeout counter.
  - `i_enable`=0 in REQ: drop the request and go to IDLE.
- RUN: the timeout counter increments each cycle.
  - `i_cfe_valid`=1: increment `o_est_cnt` (saturating at all-ones) and go to LOAD.
  - Counter = CFE_TIMEOUT-1 with no valid: go to LOAD and pulse `o_timeout`.
  - Valid and timeout in the same cycle: valid wins. Count the estimate; no timeout pulse.
  - If `i_enable`=0 at the exit cycle, go to IDLE instead of LOAD. RUN is never abandoned early.
- LOAD: lasts 1 cycle. This lets the feedback stage register its updated wait.
  - Sample `i_wait` into the countdown: load value = max(`i_wait`, 1).
  - Go to WAIT, or to IDLE if `i_enable`=0.
- WAIT: decrement the countdown each cycle. When it reaches 0, go to REQ.
  - `i_enable`=0: go to IDLE and clear the countdown.
  - Changes on `i_wait` during WAIT are ignored.
- `i_cfe_valid` outside RUN is ignored and not counted.
- `i_cfe_ready` outside REQ is ignored.

## Timing
- Reset (asynchronous, any state): state=IDLE; `o_cfe_start`=0, `o_busy`=0, `o_timeout`=0, `o_wait_cnt`=0, `o_est_cnt`=0, `o_state`=0.
- Reset mid-RUN abandons the outstanding request with no timeout pulse.
- Enable at cycle t (in IDLE): state=REQ and `o_cfe_start`=1 at t+1.
- Handshake at cycle t (start=1, ready=1): at t+1, `o_cfe_start`=0 and state=RUN.
- Valid at cycle t (in RUN):
  - t+1: LOAD, `o_est_cnt` incremented.
  - t+2: WAIT, `o_wait_cnt`=N, where N is the `i_wait` value sampled at t+1.
  - t+2+N: REQ, `o_cfe_start`=1.
- WAIT therefore lasts exactly N cycles, with N clamped to ≥1.
- RUN lasts at most CFE_TIMEOUT cycles. `o_timeout` is high for exactly the one LOAD cycle following timeout.
- Countdown arithmetic is unsigned CFE_NBW_LAT bits and never wraps below 0.

## Test plan
- Nominal cycle:
  - Stimulus: enable; ready tied 1; valid 3 cycles after start; `i_wait`=0x100 at LOAD.
  - Required: `o_cfe_start` re-asserts exactly 0x100+2 cycles after the valid; `o_est_cnt`=1; no `o_timeout`.
- Backpressure:
  - Stimulus: ready held 0 for 10 cycles in REQ.
  - Required: `o_cfe_start` stays 1 for all 10 cycles; RUN is entered the cycle after ready=1.
- Timeout:
  - Stimulus: CFE_TIMEOUT=8; no valid.
  - Required: RUN lasts 8 cycles; `o_timeout` is a 1-cycle pulse; `o_est_cnt` unchanged; WAIT loads `i_wait`.
  - Stimulus: valid on the 8th RUN cycle.
  - Required: no pulse; `o_est_cnt` incremented.
- Wait clamp and ignore:
  - Stimulus: `i_wait`=0 at LOAD.
  - Required: WAIT lasts 1 cycle.
  - Stimulus: change `i_wait` from 0x1000 to 0x10 mid-WAIT.
  - Required: the countdown is unaffected.
- Disable:
  - Stimulus: enable=0 in WAIT.
  - Required: IDLE next cycle, `o_wait_cnt`=0.
  - Stimulus: enable=0 in RUN.
  - Required: RUN completes on valid, then IDLE with `o_est_cnt` incremented.
- Async reset mid-RUN and saturation:
  - Stimulus: assert `rst_async_n`=0 during RUN.
  - Required: all outputs 0 immediately.
  - Stimulus: CFE_NBW_CNT=2; 5 estimates.
  - Required: `o_est_cnt`=3.
